// File: rtl/video_daisy_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// video_daisy_ctrl_pkg
// Shared definitions for the video daisy-chain bypass configuration sequencer:
// sequencer FSM state encoding, core index map along the chain, and the
// address of the per-core bypass control register.
// -----------------------------------------------------------------------------
package video_daisy_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Position of each core in the daisy chain (index 0 = first core).
  localparam int unsigned CORE_BAR      = 0;
  localparam int unsigned CORE_SPRITE   = 1;
  localparam int unsigned CORE_PACMAN   = 2;
  localparam int unsigned CORE_RGB2GRAY = 3;

  // Avalon-MM word address of the bypass control register in every core.
  localparam int unsigned BYPASS_REG_ADDR = 0;

endpackage

// File: rtl/video_daisy_key_debounce.sv
// -----------------------------------------------------------------------------
// video_daisy_key_debounce
// Two-flop synchronizer plus counter-based debouncer for an active-low
// pushbutton. A level change is accepted once the synchronized key has
// differed from the stable state for DEBOUNCE_CYCLES consecutive samples.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   key_n_i        raw pushbutton, active-low, asynchronous
//   press_pulse_o  one-cycle pulse when the stable state falls 1->0
// -----------------------------------------------------------------------------
module video_daisy_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_pulse_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_meta_q;
  logic          key_sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Synchronizer resets to the released level so reset release never looks
  // like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_n_i;
      key_sync_q <= key_meta_q;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (key_sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      press_d  = stable_q;   // only the released->pressed edge is a press
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_pulse_o = press_q;

endmodule

// File: rtl/video_daisy_bypass_sequencer.sv
// -----------------------------------------------------------------------------
// video_daisy_bypass_sequencer
// On a debounced key press, snapshots the switch-selected bypass bits and
// writes each bit to its core's Avalon-MM bypass register, one core at a
// time, with GAP_CYCLES idle cycles after each strobe.
//
// Ports:
//   sys_clk        system clock
//   sys_rst        synchronous active-high reset
//   key_n          raw pushbutton, active-low, asynchronous
//   bypass_sel     raw switch bits, asynchronous; bit i = bypass for core i
//   avs_address    shared register address (bypass register)
//   avs_writedata  shared write data, bit 0 = bypass value
//   avs_write      one-hot per-core write strobe
//   busy           high while a sequence is in progress
//   done           one-cycle pulse when a sequence completes
//   applied_sel    bypass bits from the last completed sequence
//
// Build option:
//   VIDEO_DAISY_AUTO_UPDATE_EN  when defined, a sequence also starts from IDLE
//                               whenever the synchronized switches differ
//                               from applied_sel.
// -----------------------------------------------------------------------------
module video_daisy_bypass_sequencer
  import video_daisy_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CORE        = 4,
  parameter int unsigned AW              = 1,
  parameter int unsigned DW              = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                key_n,
  input  logic [NUM_CORE-1:0] bypass_sel,
  output logic [AW-1:0]       avs_address,
  output logic [DW-1:0]       avs_writedata,
  output logic [NUM_CORE-1:0] avs_write,
  output logic                busy,
  output logic                done,
  output logic [NUM_CORE-1:0] applied_sel
);

  localparam int unsigned IW       = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CORE - 1);

  logic                press_pulse;
  logic                start;
  logic [NUM_CORE-1:0] sel_meta_q;
  logic [NUM_CORE-1:0] sel_sync_q;

  seq_state_e          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [NUM_CORE-1:0] shadow_q, shadow_d;
  logic [NUM_CORE-1:0] write_q, write_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NUM_CORE-1:0] applied_q, applied_d;

  video_daisy_key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk_i         (sys_clk),
    .rst_i         (sys_rst),
    .key_n_i       (key_n),
    .press_pulse_o (press_pulse)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel_meta_q <= '0;
      sel_sync_q <= '0;
    end else begin
      sel_meta_q <= bypass_sel;
      sel_sync_q <= sel_meta_q;
    end
  end

`ifdef VIDEO_DAISY_AUTO_UPDATE_EN
  // Compare against applied_d so the value committed on the DONE edge is
  // already seen and a finished sequence does not immediately retrigger.
  logic auto_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      auto_q <= 1'b0;
    end else begin
      auto_q <= (sel_sync_q != applied_d);
    end
  end

  assign start = press_pulse | auto_q;
`else
  assign start = press_pulse;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    shadow_d  = shadow_q;
    applied_d = applied_q;
    wdata_d   = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d = sel_sync_q;
          idx_d    = '0;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        gap_d = '0;
        if (GAP_CYCLES != 0) begin
          state_d = ST_GAP;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_WRITE;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_WRITE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so each is glitch-free and
    // aligned with the state it belongs to.
    write_d = (state_d == ST_WRITE) ? (NUM_CORE'(1) << idx_d) : '0;
    if (state_d == ST_WRITE) begin
      wdata_d = DW'(shadow_d[idx_d]);
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      applied_d = shadow_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      shadow_q  <= '0;
      write_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      applied_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      shadow_q  <= shadow_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      applied_q <= applied_d;
    end
  end

  assign avs_address   = AW'(BYPASS_REG_ADDR);
  assign avs_writedata = wdata_q;
  assign avs_write     = write_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign applied_sel   = applied_q;

endmodule

// File: tb/tb_video_daisy_bypass_sequencer.sv
// -----------------------------------------------------------------------------
// tb_video_daisy_bypass_sequencer
// Three sequencer instances share key/switch/reset stimulus and differ only
// in GAP_CYCLES (A=2, B=6, C=0). Strobe and done events are logged on the
// falling edge and compared against hand-computed cycle numbers.
// -----------------------------------------------------------------------------
module tb_video_daisy_bypass_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_n;
  logic [3:0] bypass_sel;

  logic        addr_a, addr_b, addr_c;
  logic [31:0] wd_a, wd_b, wd_c;
  logic [3:0]  wr_a, wr_b, wr_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [3:0]  app_a, app_b, app_c;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int oh_err   = 0;
  int busy_cnt [3];

  typedef struct {
    int          dut;
    bit          is_done;
    int          cyc;
    logic [3:0]  wr;
    logic [31:0] wd;
    logic        addr;
    logic        busy;
    logic [3:0]  app;
  } ev_t;

  ev_t evq[$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  video_daisy_bypass_sequencer #(
    .NUM_CORE(4), .AW(1), .DW(32), .DEBOUNCE_CYCLES(8), .GAP_CYCLES(2)
  ) u_dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_n(key_n), .bypass_sel(bypass_sel),
    .avs_address(addr_a), .avs_writedata(wd_a), .avs_write(wr_a),
    .busy(busy_a), .done(done_a), .applied_sel(app_a)
  );

  video_daisy_bypass_sequencer #(
    .NUM_CORE(4), .AW(1), .DW(32), .DEBOUNCE_CYCLES(8), .GAP_CYCLES(6)
  ) u_dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_n(key_n), .bypass_sel(bypass_sel),
    .avs_address(addr_b), .avs_writedata(wd_b), .avs_write(wr_b),
    .busy(busy_b), .done(done_b), .applied_sel(app_b)
  );

  video_daisy_bypass_sequencer #(
    .NUM_CORE(4), .AW(1), .DW(32), .DEBOUNCE_CYCLES(8), .GAP_CYCLES(0)
  ) u_dut_c (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_n(key_n), .bypass_sel(bypass_sel),
    .avs_address(addr_c), .avs_writedata(wd_c), .avs_write(wr_c),
    .busy(busy_c), .done(done_c), .applied_sel(app_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic log_dut(input int d, input logic [3:0] w, input logic [31:0] wd,
                         input logic ad, input logic b, input logic dn, input logic [3:0] ap);
    if (w != 4'b0000) evq.push_back('{d, 1'b0, cyc, w, wd, ad, b, ap});
    if (dn)           evq.push_back('{d, 1'b1, cyc, w, wd, ad, b, ap});
    if ($countones(w) > 1) oh_err++;
    if (b) busy_cnt[d]++;
  endtask

  always @(negedge sys_clk) begin
    log_dut(0, wr_a, wd_a, addr_a, busy_a, done_a, app_a);
    log_dut(1, wr_b, wd_b, addr_b, busy_b, done_b, app_b);
    log_dut(2, wr_c, wd_c, addr_c, busy_c, done_c, app_c);
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Events of one kind for one instance strictly after a given cycle.
  function automatic int count_ev(input int d, input bit dn, input int after);
    int n;
    n = 0;
    foreach (evq[i])
      if (evq[i].dut == d && evq[i].is_done == dn && evq[i].cyc > after) n++;
    return n;
  endfunction

  // Expects exactly one 4-strobe sequence starting at t0 and its done pulse.
  task automatic check_run(input string tag, input int d, input int t0, input int gap,
                           input logic [3:0] sel);
    int ns;
    int nd;
    ns = 0;
    nd = 0;
    foreach (evq[i]) begin
      if (evq[i].dut == d) begin
        if (!evq[i].is_done) begin
          if (ns < 4) begin
            check_eq($sformatf("%s.s%0d.cyc", tag, ns), evq[i].cyc, t0 + ns * (1 + gap));
            check_eq($sformatf("%s.s%0d.wr", tag, ns), evq[i].wr, 32'd1 << ns);
            check_eq($sformatf("%s.s%0d.wd", tag, ns), evq[i].wd, {31'd0, sel[ns]});
            check_eq($sformatf("%s.s%0d.addr", tag, ns), evq[i].addr, 0);
            check_eq($sformatf("%s.s%0d.busy", tag, ns), evq[i].busy, 1);
          end
          ns++;
        end else begin
          if (nd == 0) begin
            check_eq($sformatf("%s.done.cyc", tag), evq[i].cyc, t0 + 4 * (1 + gap));
            check_eq($sformatf("%s.done.applied", tag), evq[i].app, sel);
            check_eq($sformatf("%s.done.busy", tag), evq[i].busy, 1);
          end
          nd++;
        end
      end
    end
    check_eq($sformatf("%s.n_strobe", tag), ns, 4);
    check_eq($sformatf("%s.n_done", tag), nd, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    sys_rst    = 1'b1;
    key_n      = 1'b1;
    bypass_sel = 4'b0000;
    busy_cnt   = '{0, 0, 0};
`ifndef VIDEO_DAISY_AUTO_UPDATE_EN
    bypass_sel = 4'b1010;
`endif
    step(4);
    check_eq("rst.wr", wr_a, 0);
    check_eq("rst.wd", wd_a, 0);
    check_eq("rst.addr", addr_a, 0);
    check_eq("rst.busy", busy_a, 0);
    check_eq("rst.done", done_a, 0);
    check_eq("rst.applied", app_a, 0);
    sys_rst = 1'b0;
    step(3);

`ifdef VIDEO_DAISY_AUTO_UPDATE_EN
    // Auto-update: switch change alone launches one sequence.
    step(10);
    check_eq("T6.idle_a", count_ev(0, 0, 0), 0);
    evq.delete();
    t = cyc;
    bypass_sel = 4'b0100;
    step(50);
    check_run("T6.A", 0, t + 4, 2, 4'b0100);
    check_run("T6.B", 1, t + 4, 6, 4'b0100);
    check_run("T6.C", 2, t + 4, 0, 4'b0100);
    check_eq("T6.applied", app_a, 4'b0100);
    evq.delete();
    step(40);
    check_eq("T6.hold_a", count_ev(0, 0, 0), 0);
    check_eq("T6.hold_c", count_ev(2, 0, 0), 0);
`else
    // Test 1: basic press, bypass_sel = 1010.
    evq.delete();
    t = cyc;
    key_n = 1'b0;
    step(20);
    key_n = 1'b1;
    step(40);
    check_run("T1.A", 0, t + 11, 2, 4'b1010);
    check_run("T1.B", 1, t + 11, 6, 4'b1010);
    check_run("T1.C", 2, t + 11, 0, 4'b1010);
    check_eq("T1.applied", app_a, 4'b1010);
    check_eq("T1.busy_after", busy_a, 0);

    // Test 2: bounce shorter than the debounce window.
    evq.delete();
    busy_cnt = '{0, 0, 0};
    key_n = 1'b0; step(5);
    key_n = 1'b1; step(3);
    key_n = 1'b0; step(5);
    key_n = 1'b1; step(20);
    check_eq("T2.strobes_a", count_ev(0, 0, 0), 0);
    check_eq("T2.strobes_c", count_ev(2, 0, 0), 0);
    check_eq("T2.busy_a", busy_cnt[0], 0);

    // Test 3: second press lands while B (GAP=6) is busy and is dropped;
    // A has returned to IDLE by then and honours it.
    evq.delete();
    t = cyc;
    key_n = 1'b0; step(12);
    key_n = 1'b1; step(12);
    key_n = 1'b0; step(12);
    key_n = 1'b1; step(60);
    check_run("T3.B", 1, t + 11, 6, 4'b1010);
    check_eq("T3.A.n_strobe", count_ev(0, 0, 0), 8);
    check_eq("T3.A.second", count_ev(0, 0, t + 34), 4);

    // Test 4: switches change after the first strobe; snapshot is used.
    bypass_sel = 4'b0001;
    step(3);
    evq.delete();
    t = cyc;
    key_n = 1'b0; step(12);
    key_n = 1'b1;
    bypass_sel = 4'b1111;
    step(50);
    check_run("T4.A", 0, t + 11, 2, 4'b0001);
    check_run("T4.B", 1, t + 11, 6, 4'b0001);
    check_run("T4.C", 2, t + 11, 0, 4'b0001);
    check_eq("T4.applied", app_a, 4'b0001);

    // Test 5: reset one cycle after A's second strobe.
    evq.delete();
    t = cyc;
    key_n = 1'b0; step(12);
    key_n = 1'b1; step(3);
    sys_rst = 1'b1;
    step(1);
    check_eq("T5.wr", wr_a, 0);
    check_eq("T5.wd", wd_a, 0);
    check_eq("T5.busy", busy_a, 0);
    check_eq("T5.done", done_a, 0);
    check_eq("T5.applied", app_a, 0);
    sys_rst = 1'b0;
    step(40);
    check_eq("T5.n_strobe", count_ev(0, 0, 0), 2);
    check_eq("T5.after_rst", count_ev(0, 0, t + 15), 0);
    check_eq("T5.n_done", count_ev(0, 1, 0), 0);
    check_eq("T5.applied_hold", app_a, 0);
`endif

    check_eq("onehot", oh_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
